// File: rtl/read_register_receiver.sv
// read_register_receiver: oversampling serial receiver that assembles a 64-bit channel mask
// from the Srin/Ck read-register protocol and flags frames that stall mid-way.
module read_register_receiver #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
   input  logic        Clk,
   input  logic        Rst_N,
   input  logic        In_Enable_Receive,
   input  logic        In_Srin,
   input  logic        In_Ck,
   input  logic        In_Clear_Error,
   output logic [64:1] Out_Channel_Mask,
   output logic        Out_Mask_Valid,
   output logic        Out_Busy,
   output logic        Out_Frame_Error,
   output logic [7:0]  Out_Bit_Count
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]  state;
   logic        srin_s1, srin_s2, ck_s1, ck_s2, ck_s3;
   logic [64:1] shift;
   logic [15:0] idle_cnt;
   logic        ck_rise, timeout, fire;
   logic [64:1] shift_nxt;

   assign ck_rise   = ck_s2 & ~ck_s3;
   assign shift_nxt = {shift[63:1], srin_s2};
   assign timeout   = ({1'b0, idle_cnt} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};
   // an edge in the same cycle outranks the timeout
   assign fire      = (state == SHIFT) & In_Enable_Receive & ~ck_rise & timeout;
   assign Out_Busy  = state != IDLE;

   always_ff @(posedge Clk or negedge Rst_N) begin
      if (!Rst_N) begin
         {srin_s1, srin_s2, ck_s1, ck_s2, ck_s3} <= '0;
         state            <= IDLE;
         shift            <= '0;
         idle_cnt         <= '0;
         Out_Channel_Mask <= '0;
         Out_Mask_Valid   <= 1'b0;
         Out_Frame_Error  <= 1'b0;
         Out_Bit_Count    <= '0;
      end else begin
         srin_s1         <= In_Srin;
         srin_s2         <= srin_s1;
         ck_s1           <= In_Ck;
         ck_s2           <= ck_s1;
         ck_s3           <= ck_s2;
         Out_Mask_Valid  <= 1'b0;
         Out_Frame_Error <= fire | (Out_Frame_Error & ~In_Clear_Error);
         if (state == IDLE) begin
            idle_cnt      <= '0;
            Out_Bit_Count <= '0;
            if (In_Enable_Receive && ck_rise) begin
               shift         <= {63'd0, srin_s2};
               Out_Bit_Count <= 8'd1;
               state         <= SHIFT;
            end
         end else if (state == SHIFT) begin
            if (!In_Enable_Receive || fire) begin
               state         <= IDLE;
               Out_Bit_Count <= '0;
               idle_cnt      <= '0;
            end else if (ck_rise) begin
               shift         <= shift_nxt;
               Out_Bit_Count <= Out_Bit_Count + 8'd1;
               idle_cnt      <= '0;
               // mask and valid land together so the DONE cycle already shows the new word
               if (Out_Bit_Count == 8'd63) begin
                  state            <= DONE;
                  Out_Channel_Mask <= shift_nxt;
                  Out_Mask_Valid   <= 1'b1;
               end
            end else begin
               idle_cnt <= (idle_cnt == 16'hFFFF) ? idle_cnt : idle_cnt + 16'd1;
            end
         end else begin
            state         <= IDLE;
            Out_Bit_Count <= '0;
            idle_cnt      <= '0;
         end
      end
   end
endmodule

// File: tb/tb_read_register_receiver.sv
// tb_read_register_receiver: directed and randomized frames against a word-level model
// of the read-register protocol (sent word, expected mask, timeout latency).
module tb_read_register_receiver;
   logic        Clk = 1'b0, Rst_N = 1'b0;
   logic        en = 1'b1, srin = 1'b0, ck = 1'b0, clr = 1'b0;
   logic [64:1] mask;
   logic        valid, busy, err;
   logic [7:0]  bc;

   int vectors = 0, miscompares = 0;
   int cyc = 0, valid_cnt = 0, cnt64 = 0, bad_seq = 0, last_edge_cyc = 0, err_cyc = 0;
   logic [63:0] last_mask = '0;
   logic        prev_valid = 1'b0, prev_err = 1'b0;
   logic [7:0]  prev_bc = '0;
   logic [63:0] exp_mask = '0;

   read_register_receiver dut (
      .Clk(Clk), .Rst_N(Rst_N), .In_Enable_Receive(en), .In_Srin(srin), .In_Ck(ck),
      .In_Clear_Error(clr), .Out_Channel_Mask(mask), .Out_Mask_Valid(valid),
      .Out_Busy(busy), .Out_Frame_Error(err), .Out_Bit_Count(bc)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      cyc = cyc + 1;
      if (valid) begin
         valid_cnt = valid_cnt + 1;
         last_mask = mask;
         if (bc != 8'd64) bad_seq = bad_seq + 1;
      end
      if (prev_valid && busy) bad_seq = bad_seq + 1;
      if (bc == 8'd64) cnt64 = cnt64 + 1;
      if (bc > prev_bc) last_edge_cyc = cyc;
      if (err && !prev_err) err_cyc = cyc;
      prev_valid = valid;
      prev_err   = err;
      prev_bc    = bc;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b, input int hp, input int lo);
      srin = b;
      repeat (3) @(negedge Clk);
      ck = 1'b1;
      repeat (hp) @(negedge Clk);
      ck = 1'b0;
      repeat (lo) @(negedge Clk);
   endtask

   task automatic send_bits(input logic [63:0] w, input int n, input int hp, input int lo);
      for (int i = 0; i < n; i++) send_bit(w[63-i], hp, lo);
   endtask

   task automatic do_frame(input string tag, input logic [63:0] w, input int hp, input int lo);
      int v0, c0;
      v0 = valid_cnt;
      c0 = cnt64;
      send_bits(w, 64, hp, lo);
      repeat (6) @(negedge Clk);
      exp_mask = w;
      check({tag, "_valid"}, 64'(valid_cnt - v0), 64'd1);
      check({tag, "_mask"}, last_mask, exp_mask);
      check({tag, "_cnt64"}, 64'(cnt64 - c0), 64'd1);
      check({tag, "_idle"}, {61'd0, busy, err, 1'b0} | 64'(bc), 64'd0);
   endtask

   initial begin
      int v0;
      repeat (3) @(negedge Clk);
      check("rst_mask", mask, 64'd0);
      check("rst_flags", {61'd0, valid, busy, err}, 64'd0);
      check("rst_count", 64'(bc), 64'd0);
      Rst_N = 1'b1;
      repeat (2) @(negedge Clk);

      do_frame("f1", 64'h8000_0000_0000_0001, 4, 1);
      do_frame("b2b_a", 64'hA5A5_A5A5_5A5A_5A5A, 4, 1);
      do_frame("b2b_b", 64'hFFFF_0000_FFFF_0000, 2, 0);

      v0 = valid_cnt;
      send_bits(64'hDEAD_BEEF_0BAD_F00D, 32, 4, 1);
      check("to_partial", 64'(bc), 64'd32);
      repeat (300) @(negedge Clk);
      check("to_err", {63'd0, err}, 64'd1);
      check("to_latency", 64'(err_cyc - last_edge_cyc), 64'd256);
      check("to_novalid", 64'(valid_cnt - v0), 64'd0);
      check("to_mask", mask, exp_mask);
      check("to_idle", {63'd0, busy} | 64'(bc), 64'd0);
      clr = 1'b1;
      @(negedge Clk);
      clr = 1'b0;
      @(negedge Clk);
      check("clr_err", {63'd0, err}, 64'd0);

      v0 = valid_cnt;
      send_bits(64'h0123_4567_89AB_CDEF, 40, 4, 1);
      check("en_partial", {63'd0, busy} << 8 | 64'(bc), 64'h128);
      en = 1'b0;
      repeat (2) @(negedge Clk);
      check("en_abort", {61'd0, busy, err, valid} | 64'(bc), 64'd0);
      check("en_novalid", 64'(valid_cnt - v0), 64'd0);
      check("en_mask", mask, exp_mask);
      en = 1'b1;
      repeat (2) @(negedge Clk);
      do_frame("en_next", 64'h0000_0000_0000_00FF, 4, 1);

      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20, 4, 1);
      check("rs_partial", 64'(bc), 64'd20);
      Rst_N = 1'b0;
      #1;
      exp_mask = '0;
      check("rs_mask", mask, exp_mask);
      check("rs_flags", {61'd0, valid, busy, err} | 64'(bc), 64'd0);
      repeat (2) @(negedge Clk);
      Rst_N = 1'b1;
      repeat (2) @(negedge Clk);
      check("rs_after", {61'd0, valid, busy, err} | 64'(bc), 64'd0);
      do_frame("rs_next", 64'h1234_5678_9ABC_DEF0, 4, 1);

      do_frame("loopback", 64'h0000_0001_0000_0000, 3, 1);

      for (int i = 0; i < 6; i++)
         do_frame("rand", {$urandom, $urandom}, int'($urandom_range(2, 4)), int'($urandom_range(0, 2)));

      check("pulse_seq", 64'(bad_seq), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
